alu_op_sequencer: RTL and testbench

Instruction sequencer directly upstream of the team's 16-bit Alu. Accepts instruction words over a valid/ready handshake, reads two operands from an internal register file and drives `fn_sel`/`data_a`/`data_b` into the Alu. It waits a configurable Alu latency, then writes `data_out` back to the destination register and latches `zero_flag`/`carry_flag`. It also provides a host port for loading and inspecting registers.

---
 rtl/alu_seq_pkg.sv | 37 +++
 rtl/alu_op_sequencer_if.sv | 25 ++
 rtl/alu_seq_regfile.sv | 39 +++
 rtl/alu_op_sequencer.sv | 142 ++++++++++++++
 tb/tb_alu_op_sequencer.sv | 357 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared opcodes, FSM state type and instruction field
// positions for the alu_op_sequencer slice.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_NOTA = 4'd7;
  localparam logic [3:0] OP_NOTB = 4'd8;

  localparam int REG_ADDR_W = 3;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 9;
  localparam int RA_HI  = 8;
  localparam int RA_LO  = 6;
  localparam int RB_HI  = 5;
  localparam int RB_LO  = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } seq_state_e;

  // Opcodes above OP_NOTB have no Alu function behind them.
  function automatic logic op_legal(input logic [3:0] op);
    return (op <= OP_NOTB);
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: instruction handshake plus the Alu drive/return bus.
// slave = sequencer side, master = instruction source / Alu side.
interface alu_op_sequencer_if #(
  parameter int DATA_W = 16
);
  logic              instr_valid;
  logic [15:0]       instr;
  logic              instr_ready;
  logic [3:0]        fn_sel;
  logic [DATA_W-1:0] data_a;
  logic [DATA_W-1:0] data_b;
  logic [DATA_W-1:0] alu_data_out;
  logic              alu_zero;
  logic              alu_carry;

  modport master (
    output instr_valid, instr, alu_data_out, alu_zero, alu_carry,
    input  instr_ready, fn_sel, data_a, data_b
  );

  modport slave (
    input  instr_valid, instr, alu_data_out, alu_zero, alu_carry,
    output instr_ready, fn_sel, data_a, data_b
  );
endinterface

// File: rtl/alu_seq_regfile.sv
// alu_seq_regfile: REG_CNT x DATA_W register file, two operand read ports,
// one host read port, writeback and host write with writeback priority.
module alu_seq_regfile #(
  parameter int DATA_W  = 16,
  parameter int REG_CNT = 8,
  parameter int ADDR_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  output logic [DATA_W-1:0] host_rdata
);

  logic [DATA_W-1:0] mem [REG_CNT];

  // Host write is issued first and writeback last, so writeback wins a same-address edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_CNT; i++) mem[i] <= '0;
    end else begin
      if (host_we) mem[host_addr] <= host_wdata;
      if (wb_we)   mem[wb_addr]   <= wb_data;
    end
  end

  assign ra_data    = mem[ra_addr];
  assign rb_data    = mem[rb_addr];
  assign host_rdata = mem[host_addr];

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: accepts instructions, drives the Alu, waits ALU_LAT
// cycles and writes the result and flags back.
// Optional feature macro: ALU_SEQ_ILLEGAL_TRAP_EN (sticky err on illegal
// opcode instead of executing it as a NOP).
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int REG_CNT = 8,
  parameter int ALU_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  alu_op_sequencer_if.slave       bus,
  input  logic                    host_we,
  input  logic [REG_ADDR_W-1:0]   host_addr,
  input  logic [DATA_W-1:0]       host_wdata,
  output logic [DATA_W-1:0]       host_rdata,
  output logic                    busy,
  output logic                    done,
  output logic                    zero_q,
  output logic                    carry_q,
  output logic                    err,
  input  logic                    clr_err
);

  seq_state_e            state;
  logic [3:0]            cnt;
  logic [REG_ADDR_W-1:0] rd_q;
  logic                  nop_q;
  logic                  err_q;
  logic                  accept;
  logic                  legal;
  logic                  wb_we;
  logic [3:0]            opc;
  logic [REG_ADDR_W-1:0] rd;
  logic [REG_ADDR_W-1:0] ra;
  logic [REG_ADDR_W-1:0] rb;
  logic [DATA_W-1:0]     ra_data;
  logic [DATA_W-1:0]     rb_data;
  logic [2:0]            unused_instr;

  assign opc          = bus.instr[OPC_HI:OPC_LO];
  assign rd           = bus.instr[RD_HI:RD_LO];
  assign ra           = bus.instr[RA_HI:RA_LO];
  assign rb           = bus.instr[RB_HI:RB_LO];
  assign unused_instr = bus.instr[2:0];
  assign legal        = op_legal(opc);

  assign bus.instr_ready = rst & (state == ST_IDLE) & ~err_q;
  assign accept          = bus.instr_valid & bus.instr_ready;
  assign busy            = (state != ST_IDLE);
  assign done            = (state == ST_WB);
  assign wb_we           = done & ~nop_q;
  assign err             = err_q;

  alu_seq_regfile #(
    .DATA_W  (DATA_W),
    .REG_CNT (REG_CNT),
    .ADDR_W  (REG_ADDR_W)
  ) u_regfile (
    .clk        (clk),
    .rst        (rst),
    .wb_we      (wb_we),
    .wb_addr    (rd_q),
    .wb_data    (bus.alu_data_out),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .ra_addr    (ra),
    .rb_addr    (rb),
    .ra_data    (ra_data),
    .rb_data    (rb_data),
    .host_rdata (host_rdata)
  );

  // Sequencer FSM: accept, hold the Alu inputs for ALU_LAT cycles, then one writeback cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      rd_q       <= '0;
      nop_q      <= 1'b0;
      bus.fn_sel <= '0;
      bus.data_a <= '0;
      bus.data_b <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            rd_q <= rd;
            if (legal) begin
              bus.fn_sel <= opc;
              bus.data_a <= ra_data;
              bus.data_b <= rb_data;
              cnt        <= 4'(ALU_LAT);
              nop_q      <= 1'b0;
              state      <= ST_EXEC;
            end
`ifndef ALU_SEQ_ILLEGAL_TRAP_EN
            else begin
              nop_q <= 1'b1;
              state <= ST_WB;
            end
`endif
          end
        end
        ST_EXEC: begin
          if (cnt <= 4'd1) state <= ST_WB;
          else             cnt   <= cnt - 4'd1;
        end
        ST_WB:   state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Status flags follow the Alu only on a real (non-NOP) writeback.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else if (wb_we) begin
      zero_q  <= bus.alu_zero;
      carry_q <= bus.alu_carry;
    end
  end

`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
  // Sticky illegal-opcode error; blocks new instructions until cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                err_q <= 1'b0;
    else if (accept & ~legal) err_q <= 1'b1;
    else if (clr_err)        err_q <= 1'b0;
  end
`else
  logic unused_clr;
  assign unused_clr = clr_err;
  assign err_q      = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: bench for alu_op_sequencer with a 1-cycle Alu model,
// directed table vectors, multi-cycle corner sequences and random ops
// checked against a register-file-level reference model.
module tb_alu_op_sequencer;

  logic        clk;
  logic        rst;
  logic        host_we;
  logic [2:0]  host_addr;
  logic [15:0] host_wdata;
  logic [15:0] host_rdata;
  logic        busy;
  logic        done;
  logic        zero_q;
  logic        carry_q;
  logic        err;
  logic        clr_err;

  int total;
  int bad;

  logic [15:0] ref_rf [8];
  logic        ref_z;
  logic        ref_c;

  alu_op_sequencer_if #(.DATA_W(16)) bus ();

  alu_op_sequencer #(
    .DATA_W  (16),
    .REG_CNT (8),
    .ALU_LAT (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_rdata (host_rdata),
    .busy       (busy),
    .done       (done),
    .zero_q     (zero_q),
    .carry_q    (carry_q),
    .err        (err),
    .clr_err    (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Alu behaviour: returns {carry, zero, result}.
  function automatic logic [17:0] alu_fn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] w;
    logic        c;
    logic [15:0] r;
    w = '0;
    c = 1'b0;
    case (op)
      4'd0: begin w = 32'(a) + 32'(b); c = w[16]; end
      4'd1: begin w = 32'(a) - 32'(b); c = (a < b); end
      4'd2: begin w = 32'(a) * 32'(b); c = |w[31:16]; end
      4'd3: begin
        if (b == 16'd0) begin w = 32'h0000FFFF; c = 1'b1; end
        else            w = 32'(a / b);
      end
      4'd4: w = 32'(a & b);
      4'd5: w = 32'(a | b);
      4'd6: w = 32'(a ^ b);
      4'd7: w = 32'(~a);
      4'd8: w = 32'(~b);
      default: w = '0;
    endcase
    r = w[15:0];
    return {c, (r == 16'd0), r};
  endfunction

  // Team Alu stand-in with one cycle of latency.
  always @(posedge clk)
    {bus.alu_carry, bus.alu_zero, bus.alu_data_out} <= alu_fn(bus.fn_sel, bus.data_a, bus.data_b);

  function automatic logic [15:0] mk(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] ra, input logic [2:0] rb);
    return {op, rd, ra, rb, 3'b000};
  endfunction

  // Reference: what the register file and flags should hold after an instruction.
  function automatic void ref_exec(input logic [15:0] ins);
    logic [17:0] r;
    if (ins[15:12] > 4'd8) return;
    r = alu_fn(ins[15:12], ref_rf[ins[8:6]], ref_rf[ins[5:3]]);
    ref_rf[ins[11:9]] = r[15:0];
    ref_z = r[16];
    ref_c = r[17];
  endfunction

  task automatic chkb(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [2:0] a, input logic [15:0] d);
    host_we = 1'b1; host_addr = a; host_wdata = d;
    step();
    host_we = 1'b0;
    ref_rf[a] = d;
  endtask

  task automatic rd_reg(input logic [2:0] a, output logic [15:0] v);
    host_addr = a;
    #1;
    v = host_rdata;
  endtask

  // Issue one instruction and check the cycle-by-cycle handshake and done timing.
  task automatic exec(input logic [15:0] ins);
    int   n;
    logic lg;
    lg = (ins[15:12] <= 4'd8);
    n  = 0;
    while (bus.instr_ready !== 1'b1 && n < 20) begin step(); n++; end
    chkb("ready_wait", bus.instr_ready, 1'b1);
    bus.instr_valid = 1'b1; bus.instr = ins;
    step();
    bus.instr_valid = 1'b0;
    if (lg) begin
      chkb("exec_busy", busy, 1'b1);
      chkb("exec_done", done, 1'b0);
      chkw("exec_fn", 16'(bus.fn_sel), 16'(ins[15:12]));
      step();
    end
    chkb("wb_done", done, 1'b1);
    chkb("wb_ready", bus.instr_ready, 1'b0);
    step();
    chkb("idle_done", done, 1'b0);
    chkb("idle_busy", busy, 1'b0);
    ref_exec(ins);
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [2:0]  rd;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        z;
    logic        c;
  } vec_t;

  vec_t tbl [10];

  initial begin
    logic [15:0] v;
    logic [15:0] ins;
    logic [3:0]  op;
    int          cyc;

    tbl[0] = '{op: 4'd0, rd: 3'd3, a: 16'h2001, b: 16'h0001, res: 16'h2002, z: 1'b0, c: 1'b0};
    tbl[1] = '{op: 4'd0, rd: 3'd4, a: 16'hFFFF, b: 16'h0001, res: 16'h0000, z: 1'b1, c: 1'b1};
    tbl[2] = '{op: 4'd1, rd: 3'd5, a: 16'h0005, b: 16'h0007, res: 16'hFFFE, z: 1'b0, c: 1'b1};
    tbl[3] = '{op: 4'd2, rd: 3'd6, a: 16'h0100, b: 16'h0100, res: 16'h0000, z: 1'b1, c: 1'b1};
    tbl[4] = '{op: 4'd3, rd: 3'd7, a: 16'd100,  b: 16'd7,    res: 16'h000E, z: 1'b0, c: 1'b0};
    tbl[5] = '{op: 4'd4, rd: 3'd0, a: 16'hF0F0, b: 16'h0FF0, res: 16'h00F0, z: 1'b0, c: 1'b0};
    tbl[6] = '{op: 4'd5, rd: 3'd3, a: 16'hF000, b: 16'h000F, res: 16'hF00F, z: 1'b0, c: 1'b0};
    tbl[7] = '{op: 4'd6, rd: 3'd4, a: 16'hAAAA, b: 16'hAAAA, res: 16'h0000, z: 1'b1, c: 1'b0};
    tbl[8] = '{op: 4'd7, rd: 3'd5, a: 16'h1234, b: 16'h5555, res: 16'hEDCB, z: 1'b0, c: 1'b0};
    tbl[9] = '{op: 4'd8, rd: 3'd6, a: 16'h1234, b: 16'hFFFF, res: 16'h0000, z: 1'b1, c: 1'b0};

    total = 0; bad = 0;
    for (int i = 0; i < 8; i++) ref_rf[i] = 16'h0;
    ref_z = 1'b0; ref_c = 1'b0;
    rst = 1'b1; host_we = 1'b0; host_addr = 3'd0; host_wdata = 16'h0; clr_err = 1'b0;
    bus.instr_valid = 1'b0; bus.instr = 16'h0;

    // Reset state
    #2 rst = 1'b0;
    step(); step();
    chkb("rst_ready", bus.instr_ready, 1'b0);
    chkb("rst_busy", busy, 1'b0);
    chkb("rst_done", done, 1'b0);
    chkb("rst_err", err, 1'b0);
    chkb("rst_zero", zero_q, 1'b0);
    chkb("rst_carry", carry_q, 1'b0);
    chkw("rst_fn", 16'(bus.fn_sel), 16'h0);
    chkw("rst_da", bus.data_a, 16'h0);
    chkw("rst_db", bus.data_b, 16'h0);
    rst = 1'b1;
    #1;
    chkb("rel_ready", bus.instr_ready, 1'b1);
    for (int i = 0; i < 8; i++) begin
      rd_reg(3'(i), v);
      chkw("rst_reg", v, 16'h0);
    end
    step();

    // Directed table of every opcode
    for (int i = 0; i < 10; i++) begin
      host_write(3'd1, tbl[i].a);
      host_write(3'd2, tbl[i].b);
      exec(mk(tbl[i].op, tbl[i].rd, 3'd1, 3'd2));
      rd_reg(tbl[i].rd, v);
      chkw("tbl_res", v, tbl[i].res);
      chkb("tbl_zero", zero_q, tbl[i].z);
      chkb("tbl_carry", carry_q, tbl[i].c);
    end

    // Back-to-back with instr_valid held high: SUB r5,r1,r1 then AND r6,r5,r2
    host_write(3'd1, 16'h1234);
    host_write(3'd2, 16'h00FF);
    bus.instr_valid = 1'b1; bus.instr = mk(4'd1, 3'd5, 3'd1, 3'd1);
    step();
    bus.instr = mk(4'd4, 3'd6, 3'd5, 3'd2);
    cyc = 0;
    while (bus.instr_ready !== 1'b1 && cyc < 20) begin step(); cyc++; end
    step(); cyc++;
    bus.instr_valid = 1'b0;
    chkw("b2b_spacing", 16'(cyc), 16'd3);
    step(); step();
    chkb("b2b_idle", busy, 1'b0);
    ref_exec(mk(4'd1, 3'd5, 3'd1, 3'd1));
    ref_exec(mk(4'd4, 3'd6, 3'd5, 3'd2));
    rd_reg(3'd5, v); chkw("b2b_r5", v, 16'h0000);
    rd_reg(3'd6, v); chkw("b2b_r6", v, 16'h0000);
    step();

    // Host write in the accept cycle is not seen by that instruction's operands
    host_write(3'd1, 16'h0010);
    host_write(3'd2, 16'h0001);
    bus.instr_valid = 1'b1; bus.instr = mk(4'd0, 3'd3, 3'd1, 3'd2);
    host_we = 1'b1; host_addr = 3'd1; host_wdata = 16'h0F00;
    step();
    bus.instr_valid = 1'b0; host_we = 1'b0;
    step(); step();
    ref_exec(mk(4'd0, 3'd3, 3'd1, 3'd2));
    ref_rf[1] = 16'h0F00;
    rd_reg(3'd3, v); chkw("acc_hw_r3", v, 16'h0011);
    rd_reg(3'd1, v); chkw("acc_hw_r1", v, 16'h0F00);
    step();

    // Host write to r3 on the WB edge of ADD r3 loses to the writeback
    host_write(3'd1, 16'h2001);
    host_write(3'd2, 16'h0001);
    bus.instr_valid = 1'b1; bus.instr = mk(4'd0, 3'd3, 3'd1, 3'd2);
    step();
    bus.instr_valid = 1'b0;
    step();
    chkb("coll_wb_done", done, 1'b1);
    host_we = 1'b1; host_addr = 3'd3; host_wdata = 16'h1234;
    step();
    host_we = 1'b0;
    ref_exec(mk(4'd0, 3'd3, 3'd1, 3'd2));
    rd_reg(3'd3, v); chkw("coll_r3", v, 16'h2002);
    step();

    // Illegal opcode 0xC
    ins = mk(4'hC, 3'd3, 3'd1, 3'd2);
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    bus.instr_valid = 1'b1; bus.instr = ins;
    step();
    bus.instr_valid = 1'b0;
    chkb("trap_err", err, 1'b1);
    chkb("trap_ready", bus.instr_ready, 1'b0);
    chkb("trap_busy", busy, 1'b0);
    chkb("trap_done", done, 1'b0);
    step(); step(); step();
    chkb("trap_err_hold", err, 1'b1);
    chkb("trap_ready_hold", bus.instr_ready, 1'b0);
    chkb("trap_done_hold", done, 1'b0);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chkb("trap_clr_err", err, 1'b0);
    chkb("trap_clr_ready", bus.instr_ready, 1'b1);
`else
    clr_err = 1'b1;
    exec(ins);
    clr_err = 1'b0;
    chkb("nop_err", err, 1'b0);
`endif
    rd_reg(3'd3, v); chkw("ill_r3", v, ref_rf[3]);
    chkb("ill_zero", zero_q, ref_z);
    chkb("ill_carry", carry_q, ref_c);
    step();

    // Random instructions against the reference model
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1) host_write(3'($urandom_range(0, 7)), 16'($urandom));
      op = 4'($urandom_range(0, 8));
`ifndef ALU_SEQ_ILLEGAL_TRAP_EN
      if ($urandom_range(0, 7) == 0) op = 4'($urandom_range(9, 15));
`endif
      ins = mk(op, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      exec(ins);
      rd_reg(ins[11:9], v);
      chkw("rand_rd", v, ref_rf[ins[11:9]]);
      chkb("rand_zero", zero_q, ref_z);
      chkb("rand_carry", carry_q, ref_c);
    end
    for (int i = 0; i < 8; i++) begin
      rd_reg(3'(i), v);
      chkw("rand_sweep", v, ref_rf[i]);
    end
    step();

    // Reset asserted mid-EXEC aborts MUL r7,r1,r2
    host_write(3'd1, 16'h0003);
    host_write(3'd2, 16'h0005);
    bus.instr_valid = 1'b1; bus.instr = mk(4'd2, 3'd7, 3'd1, 3'd2);
    step();
    bus.instr_valid = 1'b0;
    chkb("abort_busy", busy, 1'b1);
    rst = 1'b0;
    #1;
    chkw("abort_fn", 16'(bus.fn_sel), 16'h0);
    chkw("abort_da", bus.data_a, 16'h0);
    chkw("abort_db", bus.data_b, 16'h0);
    chkb("abort_busy0", busy, 1'b0);
    chkb("abort_done", done, 1'b0);
    chkb("abort_zero", zero_q, 1'b0);
    chkb("abort_carry", carry_q, 1'b0);
    chkb("abort_err", err, 1'b0);
    chkb("abort_ready", bus.instr_ready, 1'b0);
    step(); step();
    rst = 1'b1;
    #1;
    chkb("abort_rel_ready", bus.instr_ready, 1'b1);
    step(); step();
    chkb("abort_no_done", done, 1'b0);
    rd_reg(3'd7, v); chkw("abort_r7", v, 16'h0000);
    rd_reg(3'd1, v); chkw("abort_r1", v, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
